// File: rtl/ycr1_wbb_burst_master.sv
// Burst Wishbone master: turns one cache refill/writeback request into a single
// Wishbone burst of req_len_i words and streams read beats back to the requester.
module ycr1_wbb_burst_master #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int BW = 4,
    parameter int BL = 10
) (
    input  logic          wbm_clk_i,
    input  logic          wbm_rst_i,
    input  logic          req_i,
    output logic          req_rdy_o,
    input  logic          req_we_i,
    input  logic [AW-1:0] req_adr_i,
    input  logic [BL-1:0] req_len_i,
    output logic [BL-1:0] wbuf_idx_o,
    input  logic [DW-1:0] wbuf_dat_i,
    output logic          rdata_vld_o,
    output logic [DW-1:0] rdata_o,
    output logic [BL-1:0] rdata_idx_o,
    output logic          rdata_last_o,
    output logic          done_o,
    output logic          done_err_o,
    output logic          wbm_cyc_o,
    output logic          wbm_stb_o,
    output logic [AW-1:0] wbm_adr_o,
    output logic          wbm_we_o,
    output logic [DW-1:0] wbm_dat_o,
    output logic [BW-1:0] wbm_sel_o,
    output logic [BL-1:0] wbm_bl_o,
    input  logic [DW-1:0] wbm_dat_i,
    input  logic          wbm_ack_i,
    input  logic          wbm_lack_i,
    input  logic          wbm_err_i
);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [BL-1:0] len_q, len_d;
    logic [BL-1:0] idx_q, idx_d;
    logic          err_q, err_d;

    logic          stb;
    logic          beat_ack;
    logic          last_idx;

    assign stb      = (state_q == S_WR) || (state_q == S_RD);
    assign beat_ack = stb & wbm_ack_i;
    assign last_idx = (idx_q == len_q - BL'(1));

    always_ff @(posedge wbm_clk_i or posedge wbm_rst_i) begin
        if (wbm_rst_i) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        idx_d   = idx_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    base_d = req_adr_i & ~AW'(3);
                    len_d  = req_len_i;
                    idx_d  = '0;
                    err_d  = 1'b0;
                    if (req_len_i == '0) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = req_we_i ? S_WR : S_RD;
                    end
                end
            end
            S_WR, S_RD: begin
                if (beat_ack) begin
                    idx_d = idx_q + BL'(1);
                    err_d = err_q | wbm_err_i;
                    // Either side disagreeing on where the burst ends is an error,
                    // but the burst is closed in both cases so the bus never hangs.
                    if (wbm_lack_i) begin
                        if (!last_idx) err_d = 1'b1;
                        state_d = S_DONE;
                    end else if (last_idx) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign req_rdy_o    = (state_q == S_IDLE);
    assign wbm_cyc_o    = stb;
    assign wbm_stb_o    = stb;
    assign wbm_we_o     = (state_q == S_WR);
    assign wbm_sel_o    = {BW{stb}};
    assign wbm_adr_o    = base_q + AW'({idx_q, 2'b00});
    assign wbm_dat_o    = wbuf_dat_i;
    assign wbm_bl_o     = len_q;
    assign wbuf_idx_o   = idx_q;

    assign rdata_vld_o  = (state_q == S_RD) & wbm_ack_i;
    assign rdata_o      = wbm_dat_i;
    assign rdata_idx_o  = idx_q;
    assign rdata_last_o = rdata_vld_o & wbm_lack_i;

    assign done_o       = (state_q == S_DONE);
    assign done_err_o   = (state_q == S_DONE) & err_q;

endmodule

// File: tb/tb_ycr1_wbb_burst_master.sv
// Bench for ycr1_wbb_burst_master: per-cycle vector table for write/boundary
// sequences, plus hand-written read, error and reset-abort sequences.
module tb_ycr1_wbb_burst_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        req_rdy;
    logic        req_we = 1'b0;
    logic [31:0] req_adr = '0;
    logic [9:0]  req_len = '0;
    logic [9:0]  wbuf_idx;
    logic [31:0] wbuf_dat;
    logic        rvld;
    logic [31:0] rdata;
    logic [9:0]  ridx;
    logic        rlast;
    logic        done;
    logic        derr;
    logic        cyc, stb, we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [9:0]  bl;
    logic [31:0] dat_in = '0;
    logic        ack = 1'b0;
    logic        lack = 1'b0;
    logic        err = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] wmodel(input logic [9:0] i);
        return (i == 10'd0) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | {22'd0, i});
    endfunction

    assign wbuf_dat = wmodel(wbuf_idx);

    ycr1_wbb_burst_master dut (
        .wbm_clk_i(clk), .wbm_rst_i(rst),
        .req_i(req), .req_rdy_o(req_rdy), .req_we_i(req_we),
        .req_adr_i(req_adr), .req_len_i(req_len),
        .wbuf_idx_o(wbuf_idx), .wbuf_dat_i(wbuf_dat),
        .rdata_vld_o(rvld), .rdata_o(rdata), .rdata_idx_o(ridx), .rdata_last_o(rlast),
        .done_o(done), .done_err_o(derr),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_adr_o(adr), .wbm_we_o(we),
        .wbm_dat_o(wdat), .wbm_sel_o(sel), .wbm_bl_o(bl),
        .wbm_dat_i(dat_in), .wbm_ack_i(ack), .wbm_lack_i(lack), .wbm_err_i(err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] adr;
        logic [9:0]  len;
        logic        ack;
        logic        lack;
        logic        err;
        logic        e_stb;
        logic        e_we;
        logic [31:0] e_adr;
        logic [9:0]  e_idx;
        logic        e_done;
        logic        e_derr;
        logic        e_rdy;
        logic [9:0]  e_bl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                                input logic [9:0] l, input logic k, input logic lk,
                                input logic e, input logic es, input logic ew,
                                input logic [31:0] ea, input logic [9:0] ei,
                                input logic ed, input logic ee, input logic er,
                                input logic [9:0] eb);
        vec_t v;
        v.req = r; v.we = w; v.adr = a; v.len = l; v.ack = k; v.lack = lk; v.err = e;
        v.e_stb = es; v.e_we = ew; v.e_adr = ea; v.e_idx = ei;
        v.e_done = ed; v.e_derr = ee; v.e_rdy = er; v.e_bl = eb;
        return v;
    endfunction

    task automatic do_read(input logic [9:0] len, input logic [31:0] a, input int err_beat,
                           input int lack_beat, input logic exp_err);
        int n;
        int last;
        n = int'(len);
        last = (lack_beat >= 0 && lack_beat < n - 1) ? lack_beat : n - 1;
        @(posedge clk); #1;
        req = 1'b1; req_we = 1'b0; req_adr = a; req_len = len;
        @(negedge clk);
        chk("rd_rdy", req_rdy, 1'b1);
        for (int i = 0; i <= last; i++) begin
            @(posedge clk); #1;
            req = 1'b0; ack = 1'b1; lack = (i == lack_beat); err = (i == err_beat);
            dat_in = 32'h100 + i;
            @(negedge clk);
            chk("rd_stb", stb, 1'b1);
            chk("rd_we", we, 1'b0);
            chk("rd_adr", adr, (a & 32'hFFFF_FFFC) + 32'(4 * i));
            chk("rd_vld", rvld, 1'b1);
            chk("rd_data", rdata, 32'h100 + i);
            chk("rd_idx", ridx, 10'(i));
            chk("rd_last", rlast, i == lack_beat);
            chk("rd_bl", bl, len);
        end
        @(posedge clk); #1;
        ack = 1'b0; lack = 1'b0; err = 1'b0;
        @(negedge clk);
        chk("rd_done", done, 1'b1);
        chk("rd_derr", derr, exp_err);
        chk("rd_stb_off", stb, 1'b0);
        chk("rd_vld_off", rvld, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rd_rdy_after", req_rdy, 1'b1);
        chk("rd_done_off", done, 1'b0);
    endtask

    initial begin
        // single write len=1
        vecs.push_back(mk(1,1,32'h1000_0004,1, 0,0,0, 0,0,32'h0,0,          0,0,1,0));
        vecs.push_back(mk(0,0,0,0,             0,0,0, 1,1,32'h1000_0004,0, 0,0,0,1));
        vecs.push_back(mk(0,0,0,0,             0,0,0, 1,1,32'h1000_0004,0, 0,0,0,1));
        vecs.push_back(mk(0,0,0,0,             1,1,0, 1,1,32'h1000_0004,0, 0,0,0,1));
        vecs.push_back(mk(0,0,0,0,             0,0,0, 0,0,32'h0,1,          1,0,0,1));
        vecs.push_back(mk(0,0,0,0,             0,0,0, 0,0,32'h0,1,          0,0,1,1));
        // write burst len=4, misaligned start, 2-cycle stalls between beats
        vecs.push_back(mk(1,1,32'h0000_2002,4, 0,0,0, 0,0,32'h0,1,          0,0,1,1));
        vecs.push_back(mk(0,0,0,0,             1,0,0, 1,1,32'h0000_2000,0, 0,0,0,4));
        vecs.push_back(mk(0,0,0,0,             0,0,0, 1,1,32'h0000_2004,1, 0,0,0,4));
        vecs.push_back(mk(0,0,0,0,             0,0,0, 1,1,32'h0000_2004,1, 0,0,0,4));
        vecs.push_back(mk(0,0,0,0,             1,0,0, 1,1,32'h0000_2004,1, 0,0,0,4));
        vecs.push_back(mk(0,0,0,0,             0,0,0, 1,1,32'h0000_2008,2, 0,0,0,4));
        vecs.push_back(mk(0,0,0,0,             0,0,0, 1,1,32'h0000_2008,2, 0,0,0,4));
        vecs.push_back(mk(0,0,0,0,             1,0,0, 1,1,32'h0000_2008,2, 0,0,0,4));
        vecs.push_back(mk(0,0,0,0,             0,0,0, 1,1,32'h0000_200C,3, 0,0,0,4));
        vecs.push_back(mk(0,0,0,0,             0,0,0, 1,1,32'h0000_200C,3, 0,0,0,4));
        vecs.push_back(mk(0,0,0,0,             1,1,0, 1,1,32'h0000_200C,3, 0,0,0,4));
        vecs.push_back(mk(0,0,0,0,             0,0,0, 0,0,32'h0,4,          1,0,0,4));
        vecs.push_back(mk(0,0,0,0,             0,0,0, 0,0,32'h0,4,          0,0,1,4));
        // len=0: no bus activity, error; then stray ack in IDLE is ignored
        vecs.push_back(mk(1,0,32'h0000_3000,0, 0,0,0, 0,0,32'h0,4,          0,0,1,4));
        vecs.push_back(mk(0,0,0,0,             0,0,0, 0,0,32'h0,0,          1,1,0,0));
        vecs.push_back(mk(0,0,0,0,             1,1,1, 0,0,32'h0,0,          0,0,1,0));
        vecs.push_back(mk(0,0,0,0,             0,0,0, 0,0,32'h0,0,          0,0,1,0));
        // address wrap at top of space
        vecs.push_back(mk(1,0,32'hFFFF_FFFC,2, 0,0,0, 0,0,32'h0,0,          0,0,1,0));
        vecs.push_back(mk(0,0,0,0,             1,0,0, 1,0,32'hFFFF_FFFC,0, 0,0,0,2));
        vecs.push_back(mk(0,0,0,0,             1,1,0, 1,0,32'h0000_0000,1, 0,0,0,2));
        vecs.push_back(mk(0,0,0,0,             0,0,0, 0,0,32'h0,2,          1,0,0,2));
        vecs.push_back(mk(0,0,0,0,             0,0,0, 0,0,32'h0,2,          0,0,1,2));

        #22;
        chk("rst_rdy", req_rdy, 1'b1);
        chk("rst_stb", stb, 1'b0);
        chk("rst_cyc", cyc, 1'b0);
        chk("rst_sel", sel, 4'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_bl", bl, 10'd0);
        chk("rst_adr", adr, 32'h0);
        chk("rst_idx", wbuf_idx, 10'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[k]) begin
            @(posedge clk); #1;
            req = vecs[k].req; req_we = vecs[k].we; req_adr = vecs[k].adr; req_len = vecs[k].len;
            ack = vecs[k].ack; lack = vecs[k].lack; err = vecs[k].err;
            dat_in = 32'h5555_0000;
            @(negedge clk);
            chk("v_rdy", req_rdy, vecs[k].e_rdy);
            chk("v_stb", stb, vecs[k].e_stb);
            chk("v_cyc", cyc, vecs[k].e_stb);
            chk("v_sel", sel, vecs[k].e_stb ? 4'hF : 4'h0);
            chk("v_we", we, vecs[k].e_we);
            if (vecs[k].e_stb) chk("v_adr", adr, vecs[k].e_adr);
            if (vecs[k].e_stb && vecs[k].e_we) chk("v_wdat", wdat, wmodel(vecs[k].e_idx));
            chk("v_idx", wbuf_idx, vecs[k].e_idx);
            chk("v_done", done, vecs[k].e_done);
            chk("v_derr", derr, vecs[k].e_derr);
            chk("v_bl", bl, vecs[k].e_bl);
            chk("v_rvld", rvld, vecs[k].e_stb & ~vecs[k].e_we & vecs[k].ack);
        end
        @(posedge clk); #1;
        req = 1'b0; ack = 1'b0; lack = 1'b0; err = 1'b0;

        do_read(10'd8, 32'h0000_8000, -1, 7, 1'b0);
        do_read(10'd4, 32'h0000_9000, 1, 3, 1'b1);
        do_read(10'd4, 32'h0000_A000, -1, 1, 1'b1);
        do_read(10'd3, 32'h0000_B000, -1, -1, 1'b1);

        // reset in the middle of an 8-beat write
        @(posedge clk); #1;
        req = 1'b1; req_we = 1'b1; req_adr = 32'h0000_4000; req_len = 10'd8;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            req = 1'b0; ack = 1'b1;
            @(negedge clk);
            chk("ab_adr", adr, 32'h0000_4000 + 32'(4 * i));
            chk("ab_wdat", wdat, wmodel(10'(i)));
        end
        @(posedge clk); #1;
        ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("ab_stb", stb, 1'b0);
        chk("ab_cyc", cyc, 1'b0);
        chk("ab_sel", sel, 4'h0);
        chk("ab_done", done, 1'b0);
        @(negedge clk);
        chk("ab_bl", bl, 10'd0);
        @(posedge clk); #1;
        chk("ab_done2", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ab_done3", done, 1'b0);
        req = 1'b1; req_we = 1'b1; req_adr = 32'h0000_5000; req_len = 10'd1;
        @(negedge clk);
        chk("ab_rdy", req_rdy, 1'b1);
        @(posedge clk); #1;
        req = 1'b0; ack = 1'b1; lack = 1'b1;
        @(negedge clk);
        chk("ab2_stb", stb, 1'b1);
        chk("ab2_adr", adr, 32'h0000_5000);
        chk("ab2_bl", bl, 10'd1);
        chk("ab2_wdat", wdat, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        ack = 1'b0; lack = 1'b0;
        @(negedge clk);
        chk("ab2_done", done, 1'b1);
        chk("ab2_derr", derr, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
